// File: rtl/ifu_pkg.sv
// Shared IFU types: cache/fill-engine handshake payloads and fill FSM states.
package ifu_pkg;

    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned WORD_WIDTH   = 32;
    localparam int unsigned CL_WIDTH     = 128;
    localparam int unsigned WORDS_PER_CL = CL_WIDTH / WORD_WIDTH;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_FETCH = 2'd1,
        F_RESP  = 2'd2
    } t_fill_states;

    typedef struct packed {
        logic                  fill_requested_address_valid;
        logic [ADDR_WIDTH-1:0] fill_requested_address;
    } t_cache2i_mem_req;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] address;
        logic [CL_WIDTH-1:0]   filled_instruction;
    } t_i_mem2cache_rsp;

endpackage

// File: rtl/ifu_line_fill.sv
// Miss-fill engine: fetches a 16-byte line as four in-order word reads and
// returns it to the i_cache as a single-cycle response with a held payload.
module ifu_line_fill
    import ifu_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  t_cache2i_mem_req      cache2i_mem_req,
    output t_i_mem2cache_rsp      i_mem2cache_rsp,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [WORD_WIDTH-1:0] mem_rsp_data,
    output logic                  fill_busy,
    output logic                  fill_err
);

    localparam int unsigned CNT_W      = 3;
    localparam int unsigned OFF_W      = $clog2(WORDS_PER_CL);
    localparam int unsigned LINE_OFF_W = $clog2(CL_WIDTH / 8);
    localparam int unsigned TAG_W      = ADDR_WIDTH - LINE_OFF_W;

    t_fill_states                         state;
    logic [TAG_W-1:0]                     line_tag;
    logic [CNT_W-1:0]                     issue_cnt;
    logic [CNT_W-1:0]                     rx_cnt;
    logic [CNT_W-1:0]                     outst_cnt;
    logic [WORDS_PER_CL-1:0][WORD_WIDTH-1:0] line;

    logic                                 req_accept;
    logic                                 rsp_take;
    logic                                 rsp_spurious;
    logic                                 req_illegal;
    logic [CNT_W-1:0]                     issue_nxt;
    logic [CNT_W-1:0]                     rx_nxt;
    logic [CNT_W-1:0]                     outst_nxt;
    logic [WORDS_PER_CL-1:0][WORD_WIDTH-1:0] line_nxt;

    // The word offset of the request is irrelevant: the whole line is fetched.
    logic unused_offset_bits;
    assign unused_offset_bits = ^cache2i_mem_req.fill_requested_address[LINE_OFF_W-1:0];

    // Handshake decode and next counter/line values for this cycle.
    always_comb begin
        req_accept   = mem_req_valid & mem_req_ready;
        rsp_take     = mem_rsp_valid & (outst_cnt != '0);
        rsp_spurious = mem_rsp_valid & (outst_cnt == '0);
        req_illegal  = cache2i_mem_req.fill_requested_address_valid & (state != F_IDLE);
        issue_nxt    = issue_cnt + CNT_W'(req_accept);
        rx_nxt       = rx_cnt + CNT_W'(rsp_take);
        outst_nxt    = outst_cnt + CNT_W'(req_accept) - CNT_W'(rsp_take);
        line_nxt     = line;
        if (rsp_take) begin
            line_nxt[rx_cnt[OFF_W-1:0]] = mem_rsp_data;
        end
    end

    // Fill FSM with registered memory-request, response and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= F_IDLE;
            line_tag        <= '0;
            issue_cnt       <= '0;
            rx_cnt          <= '0;
            outst_cnt       <= '0;
            line            <= '0;
            i_mem2cache_rsp <= '0;
            mem_req_valid   <= 1'b0;
            mem_req_addr    <= '0;
            fill_busy       <= 1'b0;
            fill_err        <= 1'b0;
        end else begin
            if (req_illegal || rsp_spurious) begin
                fill_err <= 1'b1;
            end
            unique case (state)
                F_IDLE: begin
                    if (cache2i_mem_req.fill_requested_address_valid) begin
                        line_tag      <= cache2i_mem_req.fill_requested_address[ADDR_WIDTH-1:LINE_OFF_W];
                        issue_cnt     <= '0;
                        rx_cnt        <= '0;
                        outst_cnt     <= '0;
                        mem_req_valid <= 1'b1;
                        mem_req_addr  <= {cache2i_mem_req.fill_requested_address[ADDR_WIDTH-1:LINE_OFF_W],
                                          LINE_OFF_W'(0)};
                        fill_busy     <= 1'b1;
                        state         <= F_FETCH;
                    end
                end
                F_FETCH: begin
                    issue_cnt     <= issue_nxt;
                    rx_cnt        <= rx_nxt;
                    outst_cnt     <= outst_nxt;
                    line          <= line_nxt;
                    // Offset wraps within the line; the tag is never incremented.
                    mem_req_valid <= (issue_nxt < CNT_W'(WORDS_PER_CL)) &&
                                     (outst_nxt < CNT_W'(MAX_OUTSTANDING));
                    mem_req_addr  <= {line_tag, issue_nxt[OFF_W-1:0], 2'b00};
                    if (rx_nxt == CNT_W'(WORDS_PER_CL)) begin
                        i_mem2cache_rsp.valid              <= 1'b1;
                        i_mem2cache_rsp.address            <= {line_tag, LINE_OFF_W'(0)};
                        i_mem2cache_rsp.filled_instruction <= line_nxt;
                        state                              <= F_RESP;
                    end
                end
                F_RESP: begin
                    i_mem2cache_rsp.valid <= 1'b0;
                    fill_busy             <= 1'b0;
                    state                 <= F_IDLE;
                end
                default: begin
                    state <= F_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_line_fill.sv
// Randomized scoreboard bench for ifu_line_fill with an in-order memory model.
module tb_ifu_line_fill;
    import ifu_pkg::*;

    localparam int unsigned MAX_OUT = 2;

    logic                  clk = 1'b0;
    logic                  rst_n;
    t_cache2i_mem_req      cache2i_mem_req;
    t_i_mem2cache_rsp      i_mem2cache_rsp;
    logic                  mem_req_valid;
    logic [31:0]           mem_req_addr;
    logic                  mem_req_ready;
    logic                  mem_rsp_valid;
    logic [31:0]           mem_rsp_data;
    logic                  fill_busy;
    logic                  fill_err;

    ifu_line_fill #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cache2i_mem_req (cache2i_mem_req),
        .i_mem2cache_rsp (i_mem2cache_rsp),
        .mem_req_valid   (mem_req_valid),
        .mem_req_addr    (mem_req_addr),
        .mem_req_ready   (mem_req_ready),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .fill_busy       (fill_busy),
        .fill_err        (fill_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          due;
    } mem_ent_t;

    int               checks = 0;
    int               failures = 0;
    mem_ent_t         mem_q[$];
    logic [31:0]      exp_addr_q[$];
    t_i_mem2cache_rsp exp_q[$];
    t_i_mem2cache_rsp last_exp;
    logic [31:0]      salt = 32'h0;
    int               mem_lat = 1;
    int               ready_mode = 0;
    int               pat_i = 0;
    logic [4:0]       ready_pat = 5'b10010;
    bit               spur_req = 1'b0;
    bit               spur_on = 1'b0;
    int               req_cyc = 0;
    bit               lat_chk = 1'b0;
    int               fill_acc_n = 0;
    int               fill_take_n = 0;
    int               first_take_cyc = 0;
    int               third_acc_cyc = 0;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference line: word k of the aligned line is whatever memory holds at base+4k.
    function automatic t_i_mem2cache_rsp model_fill(input logic [31:0] addr, input logic [31:0] s);
        t_i_mem2cache_rsp r;
        logic [31:0]      b;
        b = addr & 32'hFFFF_FFF0;
        r.valid   = 1'b1;
        r.address = b;
        r.filled_instruction = '0;
        for (int k = 0; k < 4; k++) begin
            r.filled_instruction[32*k +: 32] = (b + 32'(4 * k)) ^ s;
        end
        return r;
    endfunction

    // Word memory: in-order replies mem_lat cycles after acceptance, shares rst_n.
    initial begin
        bit          acc;
        bit          took;
        logic [31:0] a;
        mem_ent_t    ent;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_req_ready = 1'b0;
        forever begin
            @(negedge clk);
            acc  = rst_n && mem_req_valid && mem_req_ready;
            a    = mem_req_addr;
            took = rst_n && mem_rsp_valid && !spur_on;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                mem_q.delete();
            end else begin
                if (took && mem_q.size() > 0) begin
                    void'(mem_q.pop_front());
                    fill_take_n++;
                    if (fill_take_n == 1) first_take_cyc = cyc;
                end
                if (acc) begin
                    fill_acc_n++;
                    if (fill_acc_n == 3) third_acc_cyc = cyc;
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL req_addr_unexpected: got %h with no request expected", a);
                    end else begin
                        check("req_addr_order", 192'(a), 192'(exp_addr_q.pop_front()));
                    end
                    ent.data = a ^ salt;
                    ent.due  = cyc + mem_lat - 1;
                    mem_q.push_back(ent);
                end
            end
            spur_on = 1'b0;
            if (spur_req) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hDEAD_BEEF;
                spur_on       = 1'b1;
                spur_req      = 1'b0;
            end else if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_q[0].data;
            end else begin
                mem_rsp_valid = 1'b0;
            end
            case (ready_mode)
                0:       mem_req_ready = 1'b1;
                1:       begin mem_req_ready = ready_pat[pat_i]; pat_i = (pat_i + 1) % 5; end
                default: mem_req_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard for responses plus request-side protocol checks.
    initial begin
        t_i_mem2cache_rsp e;
        bit               prev_rv = 1'b0;
        bit               prev_stall = 1'b0;
        logic [31:0]      prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (i_mem2cache_rsp.valid) begin
                    check("rsp_single_cycle", 192'(prev_rv), 192'(0));
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_unexpected: got address %h with no fill pending", i_mem2cache_rsp.address);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_address", 192'(i_mem2cache_rsp.address), 192'(e.address));
                        check("rsp_line", 192'(i_mem2cache_rsp.filled_instruction), 192'(e.filled_instruction));
                        last_exp = e;
                    end
                    if (lat_chk) begin
                        check("rsp_latency", 192'(cyc - req_cyc), 192'(5));
                        lat_chk = 1'b0;
                    end
                end
                if (prev_stall) begin
                    check("req_hold_valid", 192'(mem_req_valid), 192'(1));
                    check("req_hold_addr", 192'(mem_req_addr), 192'(prev_addr));
                end
                if (mem_req_valid) begin
                    check("outstanding_cap", 192'(mem_q.size() < MAX_OUT), 192'(1));
                end
            end
            prev_rv    = rst_n && i_mem2cache_rsp.valid;
            prev_stall = rst_n && mem_req_valid && !mem_req_ready;
            prev_addr  = mem_req_addr;
        end
    end

    // Drives one legal fill request; caller is positioned just after a clock edge.
    task automatic issue_fill(input logic [31:0] addr, input logic [31:0] s);
        t_i_mem2cache_rsp e;
        salt = s;
        e = model_fill(addr, s);
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(e.address + 32'(4 * k));
        exp_q.push_back(e);
        fill_acc_n  = 0;
        fill_take_n = 0;
        req_cyc     = cyc + 1;
        cache2i_mem_req.fill_requested_address_valid = 1'b1;
        cache2i_mem_req.fill_requested_address       = addr;
        @(posedge clk);
        #1;
        cache2i_mem_req.fill_requested_address_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((fill_busy || exp_q.size() != 0 || mem_q.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 400) begin
            failures++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, n);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp"}, 192'(i_mem2cache_rsp), 192'(0));
        check({tag, "_req_valid"}, 192'(mem_req_valid), 192'(0));
        check({tag, "_req_addr"}, 192'(mem_req_addr), 192'(0));
        check({tag, "_busy"}, 192'(fill_busy), 192'(0));
        check({tag, "_err"}, 192'(fill_err), 192'(0));
    endtask

    task automatic do_reset(input string tag);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        exp_addr_q.delete();
        lat_chk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        cache2i_mem_req = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic fill with fixed expectations from the worked example.
        ready_mode = 0;
        mem_lat    = 1;
        lat_chk    = 1'b1;
        issue_fill(32'h0000_1238, 32'hA5A5_0000);
        wait_idle("basic");
        check("basic_address", 192'(i_mem2cache_rsp.address), 192'(32'h0000_1230));
        check("basic_line", 192'(i_mem2cache_rsp.filled_instruction),
              192'(128'hA5A5123C_A5A51238_A5A51234_A5A51230));

        // Payload stays put while idle.
        repeat (10) begin
            @(negedge clk);
            check("hold_valid", 192'(i_mem2cache_rsp.valid), 192'(0));
            check("hold_address", 192'(i_mem2cache_rsp.address), 192'(last_exp.address));
            check("hold_line", 192'(i_mem2cache_rsp.filled_instruction), 192'(last_exp.filled_instruction));
        end
        @(posedge clk);
        #1;

        // Backpressure with ready pattern 0,1,0,0,1.
        ready_mode = 1;
        pat_i      = 0;
        issue_fill($urandom, $urandom);
        wait_idle("backpressure");

        // Outstanding cap with slow memory.
        ready_mode = 0;
        mem_lat    = 5;
        issue_fill(32'h0004_5670, $urandom);
        wait_idle("cap");
        check("cap_third_issue", 192'(third_acc_cyc - first_take_cyc), 192'(1));

        // Second request while fetching is dropped and flagged.
        mem_lat = 3;
        issue_fill(32'h0000_8000, $urandom);
        repeat (2) begin @(posedge clk); #1; end
        check("err_a_before", 192'(fill_err), 192'(0));
        cache2i_mem_req.fill_requested_address_valid = 1'b1;
        cache2i_mem_req.fill_requested_address       = 32'h0BAD_0000;
        @(posedge clk);
        #1;
        cache2i_mem_req.fill_requested_address_valid = 1'b0;
        wait_idle("err_a");
        check("err_a_flag", 192'(fill_err), 192'(1));

        do_reset("rst_clear");

        // Spurious read data while idle is flagged, then a fill still works.
        mem_lat  = 1;
        spur_req = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        check("err_b_flag", 192'(fill_err), 192'(1));
        issue_fill(32'h0001_0010, $urandom);
        wait_idle("err_b_fill");
        check("err_b_sticky", 192'(fill_err), 192'(1));

        // Reset after two beats abandons the fill.
        issue_fill(32'h0002_0020, $urandom);
        n = 0;
        while (fill_take_n < 2 && n < 50) begin @(posedge clk); #1; n++; end
        check("midfill_beats", 192'(fill_take_n >= 2), 192'(1));
        do_reset("midfill");
        repeat (3) begin @(posedge clk); #1; end
        issue_fill(32'hFFFF_FFF0, $urandom);
        wait_idle("top_line");

        // Randomized fills: random address, data, latency, ready and gaps.
        ready_mode = 2;
        for (int i = 0; i < 30; i++) begin
            mem_lat = int'($urandom_range(1, 5));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            issue_fill($urandom, $urandom);
            wait_idle("random");
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
